// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, requester count and op legality helper
package alu_pkg;

  localparam int NREQ = 2;

  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_SUB    = 4'd2;
  localparam logic [3:0] ALU_AND    = 4'd3;
  localparam logic [3:0] ALU_OR     = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_LUI    = 4'd6;
  localparam logic [3:0] ALU_SLT    = 4'd7;
  localparam logic [3:0] ALU_SLL    = 4'd8;
  localparam logic [3:0] ALU_SRL    = 4'd9;
  localparam logic [3:0] ALU_OP_MAX = 4'd9;

  // Code 0 doubles as the ALU idle op, so it is not a legal request.
  function automatic logic alu_op_legal(input logic [3:0] ctrl);
    return (ctrl != 4'd0) && (ctrl <= ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way arbiter: fixed priority with starvation guard, or round-robin
module rr_arb2 #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       mode,
  output logic [1:0] grant
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt;
  logic           rr_last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
          if (mode) grant = rr_last ? 2'b01 : 2'b10;
          else      grant = (wait_cnt == WAIT_LIMIT) ? 2'b10 : 2'b01;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  // rr_last=1 means port 1 was served last, so port 0 is favoured next.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last  <= 1'b1;
      wait_cnt <= '0;
    end else if (grant[1]) begin
      rr_last  <= 1'b1;
      wait_cnt <= '0;
    end else if (grant[0]) begin
      rr_last <= 1'b0;
      if (valid[1] && (wait_cnt != WAIT_LIMIT))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - shares one combinational ALU between EX stage and branch helper
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DW       = 32,
  parameter int SHW      = 6,
  parameter int CW       = 4,
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_data1,
  input  logic [NREQ*DW-1:0]  req_data2,
  input  logic [NREQ*SHW-1:0] req_shamt,
  input  logic [NREQ*CW-1:0]  req_ctrl,
  output logic [DW-1:0]       alu_data1,
  output logic [DW-1:0]       alu_data2,
  output logic [SHW-1:0]      alu_shamt,
  output logic [CW-1:0]       alu_ctrl,
  input  logic [DW-1:0]       alu_res,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_res,
  output logic                rsp_id,
  output logic                rsp_err
);

  logic           can_issue;
  logic           arb_en;
  logic [1:0]     grant;
  logic           any_grant;
  logic           gid;
  logic [DW-1:0]  sel_data1;
  logic [DW-1:0]  sel_data2;
  logic [SHW-1:0] sel_shamt;
  logic [CW-1:0]  sel_ctrl;

  // A full response register blocks issue unless it drains on this same edge.
  assign can_issue = !rsp_valid || rsp_ready;
  assign arb_en    = can_issue && !rst;

  rr_arb2 #(
    .MAX_WAIT(MAX_WAIT)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .valid(req_valid),
    .en   (arb_en),
    .mode (ARB_MODE != 0),
    .grant(grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign gid       = grant[1];

  assign sel_data1 = gid ? req_data1[DW +: DW]   : req_data1[0 +: DW];
  assign sel_data2 = gid ? req_data2[DW +: DW]   : req_data2[0 +: DW];
  assign sel_shamt = gid ? req_shamt[SHW +: SHW] : req_shamt[0 +: SHW];
  assign sel_ctrl  = gid ? req_ctrl[CW +: CW]    : req_ctrl[0 +: CW];

  // Idle cycles drive op 0 so the ALU output settles to zero.
  assign alu_data1 = any_grant ? sel_data1 : '0;
  assign alu_data2 = any_grant ? sel_data2 : '0;
  assign alu_shamt = any_grant ? sel_shamt : '0;
  assign alu_ctrl  = any_grant ? sel_ctrl  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (any_grant) begin
      rsp_valid <= 1'b1;
      rsp_res   <= alu_res;
      rsp_id    <= gid;
      rsp_err   <= !alu_op_legal(sel_ctrl);
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb (fixed and rr instances)
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int DW  = 32;
  localparam int SHW = 6;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [2*DW-1:0]  req_data1 = '0;
  logic [2*DW-1:0]  req_data2 = '0;
  logic [2*SHW-1:0] req_shamt = '0;
  logic [2*CW-1:0]  req_ctrl  = '0;
  logic          rsp_ready = 1'b1;

  logic [1:0]    f_ready, r_ready;
  logic [DW-1:0] f_alu_d1, f_alu_d2, r_alu_d1, r_alu_d2;
  logic [SHW-1:0] f_alu_sh, r_alu_sh;
  logic [CW-1:0] f_alu_ctrl, r_alu_ctrl;
  logic [DW-1:0] f_alu_res, r_alu_res;
  logic          f_rsp_valid, r_rsp_valid;
  logic [DW-1:0] f_rsp_res, r_rsp_res;
  logic          f_rsp_id, r_rsp_id, f_rsp_err, r_rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [SHW-1:0] sh, input logic [CW-1:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_LUI: return b;
      ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
      ALU_SLL: return a << sh;
      ALU_SRL: return a >> sh;
      default: return '0;
    endcase
  endfunction

  assign f_alu_res = alu_model(f_alu_d1, f_alu_d2, f_alu_sh, f_alu_ctrl);
  assign r_alu_res = alu_model(r_alu_d1, r_alu_d2, r_alu_sh, r_alu_ctrl);

  alu_share_arb #(.DW(DW), .SHW(SHW), .CW(CW), .ARB_MODE(0), .MAX_WAIT(4)) u_fix (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(f_ready),
    .req_data1(req_data1), .req_data2(req_data2), .req_shamt(req_shamt), .req_ctrl(req_ctrl),
    .alu_data1(f_alu_d1), .alu_data2(f_alu_d2), .alu_shamt(f_alu_sh), .alu_ctrl(f_alu_ctrl),
    .alu_res(f_alu_res), .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(f_rsp_res), .rsp_id(f_rsp_id), .rsp_err(f_rsp_err)
  );

  alu_share_arb #(.DW(DW), .SHW(SHW), .CW(CW), .ARB_MODE(1), .MAX_WAIT(4)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r_ready),
    .req_data1(req_data1), .req_data2(req_data2), .req_shamt(req_shamt), .req_ctrl(req_ctrl),
    .alu_data1(r_alu_d1), .alu_data2(r_alu_d2), .alu_shamt(r_alu_sh), .alu_ctrl(r_alu_ctrl),
    .alu_res(r_alu_res), .rsp_valid(r_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(r_rsp_res), .rsp_id(r_rsp_id), .rsp_err(r_rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                          input logic [SHW-1:0] sh, input logic [CW-1:0] op);
    req_data1[p*DW +: DW]   = d1;
    req_data2[p*DW +: DW]   = d2;
    req_shamt[p*SHW +: SHW] = sh;
    req_ctrl[p*CW +: CW]    = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_port(0, 0, 0, 0, ALU_ADD);
    set_port(1, 0, 0, 0, ALU_ADD);
    req_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      n_checks++;
      if (f_rsp_valid !== 1'b0 || r_rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rsp_valid cyc%0d: got fix=%b rr=%b want 0", i, f_rsp_valid, r_rsp_valid);
      end
      n_checks++;
      if (f_ready !== 2'b00 || r_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_req_ready cyc%0d: got fix=%b rr=%b want 00", i, f_ready, r_ready);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (f_ready !== 2'b01 || r_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL first_grant: got fix=%b rr=%b want 01", f_ready, r_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_single_add();
    set_port(0, 5, 7, 0, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (f_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL add_ready: got %b want 01", f_ready);
    end
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (f_rsp_valid !== 1'b1 || f_rsp_res !== 32'd12 || f_rsp_id !== 1'b0 || f_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL add_rsp: got v=%b res=%0d id=%b err=%b want v=1 res=12 id=0 err=0",
               f_rsp_valid, f_rsp_res, f_rsp_id, f_rsp_err);
    end
    tick();
  endtask

  task automatic test_fixed_starvation();
    logic [1:0] exp_g;
    do_reset();
    set_port(0, 1, 1, 0, ALU_ADD);
    set_port(1, 10, 3, 0, ALU_SUB);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_g = (i == 4 || i == 9) ? 2'b10 : 2'b01;
      #1;
      n_checks++;
      if (f_ready !== exp_g) begin
        n_fail++;
        $display("FAIL fixed_grant cyc%0d: got %b want %b", i, f_ready, exp_g);
      end
      tick();
      n_checks++;
      if (f_rsp_valid !== 1'b1 || f_rsp_id !== exp_g[1] ||
          f_rsp_res !== (exp_g[1] ? 32'd7 : 32'd2)) begin
        n_fail++;
        $display("FAIL fixed_rsp cyc%0d: got v=%b id=%b res=%0d want v=1 id=%b res=%0d",
                 i, f_rsp_valid, f_rsp_id, f_rsp_res, exp_g[1], exp_g[1] ? 7 : 2);
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    set_port(0, 32'h0000_00F0, 32'h0000_0FF0, 0, ALU_AND);
    set_port(1, 32'h0000_00F0, 32'h0000_0F00, 0, ALU_OR);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if (r_ready !== exp_g) begin
        n_fail++;
        $display("FAIL rr_grant cyc%0d: got %b want %b", i, r_ready, exp_g);
      end
      tick();
      n_checks++;
      if (r_rsp_valid !== 1'b1 || r_rsp_id !== exp_g[1] ||
          r_rsp_res !== (exp_g[1] ? 32'h0000_0FF0 : 32'h0000_00F0)) begin
        n_fail++;
        $display("FAIL rr_rsp cyc%0d: got v=%b id=%b res=%h want v=1 id=%b",
                 i, r_rsp_valid, r_rsp_id, r_rsp_res, exp_g[1]);
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    set_port(0, 1, 0, 4, ALU_SLL);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (f_rsp_valid !== 1'b1 || f_rsp_res !== 32'd16) begin
      n_fail++;
      $display("FAIL sll_rsp: got v=%b res=%0d want v=1 res=16", f_rsp_valid, f_rsp_res);
    end
    set_port(0, 2, 3, 0, ALU_ADD);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (f_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_ready cyc%0d: got %b want 00", i, f_ready);
      end
      tick();
      n_checks++;
      if (f_rsp_valid !== 1'b1 || f_rsp_res !== 32'd16 || f_rsp_id !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got v=%b res=%0d id=%b want v=1 res=16 id=0",
                 i, f_rsp_valid, f_rsp_res, f_rsp_id);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (f_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 01", f_ready);
    end
    tick();
    n_checks++;
    if (f_rsp_valid !== 1'b1 || f_rsp_res !== 32'd5) begin
      n_fail++;
      $display("FAIL bp_replace: got v=%b res=%0d want v=1 res=5", f_rsp_valid, f_rsp_res);
    end
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (f_alu_ctrl !== 4'd0 || f_alu_d1 !== 32'd0 || f_alu_d2 !== 32'd0 || f_alu_sh !== 6'd0) begin
      n_fail++;
      $display("FAIL idle_alu_drive: got ctrl=%h d1=%h d2=%h sh=%h want all 0",
               f_alu_ctrl, f_alu_d1, f_alu_d2, f_alu_sh);
    end
    tick();
    n_checks++;
    if (f_rsp_valid !== 1'b0 || f_rsp_res !== 32'd5) begin
      n_fail++;
      $display("FAIL drain_hold: got v=%b res=%0d want v=0 res=5", f_rsp_valid, f_rsp_res);
    end
  endtask

  task automatic test_illegal_and_reset();
    set_port(1, 3, 4, 0, 4'hF);
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (f_rsp_valid !== 1'b1 || f_rsp_res !== 32'd0 || f_rsp_err !== 1'b1 || f_rsp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_rsp: got v=%b res=%0d err=%b id=%b want v=1 res=0 err=1 id=1",
               f_rsp_valid, f_rsp_res, f_rsp_err, f_rsp_id);
    end
    set_port(0, 5, 7, 0, ALU_ADD);
    req_valid = 2'b01;
    tick();
    n_checks++;
    if (f_rsp_res !== 32'd12 || f_rsp_err !== 1'b0 || f_rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL after_illegal: got res=%0d err=%b id=%b want res=12 err=0 id=0",
               f_rsp_res, f_rsp_err, f_rsp_id);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (f_rsp_valid !== 1'b0 || f_rsp_res !== 32'd0 || r_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midstream_reset: got fix v=%b res=%0d rr v=%b want v=0 res=0",
               f_rsp_valid, f_rsp_res, r_rsp_valid);
    end
    rst = 1'b0;
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fixed_starvation();
    test_round_robin();
    test_backpressure();
    test_illegal_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
